// File: rtl/apb_drain_ctrl.sv
// Drains a FIFO of {address, data} entries onto an APB bus as single writes,
// with optional access timeout, sticky error flag and saturating statistics.
module apb_drain_ctrl #(
    parameter int DSIZE   = 32,
    parameter int AWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              enable,
    input  logic              fifo_rempty,
    input  logic [DSIZE-1:0]  fifo_rdata,
    input  logic [AWIDTH-1:0] fifo_addr,
    output logic              fifo_rinc,
    output logic [AWIDTH-1:0] paddr,
    output logic [DSIZE-1:0]  pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy,
    output logic              err_irq,
    input  logic              err_clr,
    output logic [15:0]       xfer_cnt,
    output logic [7:0]        err_cnt
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              armed_reg;
    logic [TW-1:0]     tmo_cnt_reg, tmo_cnt_next;
    logic [AWIDTH-1:0] paddr_reg;
    logic [DSIZE-1:0]  pwdata_reg;
    logic [15:0]       xfer_cnt_reg, xfer_cnt_next;
    logic [7:0]        err_cnt_reg, err_cnt_next;
    logic              err_irq_reg, err_irq_next;

    logic can_pop;
    logic pop;
    logic done;
    logic timeout_hit;
    logic err_ev;

    // armed_reg keeps the first pop off the first edge after reset release
    assign can_pop = armed_reg && enable && !fifo_rempty;
    assign done    = (state_reg == ACCESS) && pready;
    assign err_ev  = (done && pslverr) || timeout_hit;

    generate
        if (TIMEOUT == 0) begin : g_no_tmo
            assign timeout_hit  = 1'b0;
            assign tmo_cnt_next = '0;
        end else begin : g_tmo
            assign timeout_hit  = (state_reg == ACCESS) && !pready &&
                                  (tmo_cnt_reg == TW'(TIMEOUT - 1));
            assign tmo_cnt_next = ((state_reg == ACCESS) && !pready && !timeout_hit)
                                  ? tmo_cnt_reg + TW'(1) : '0;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (can_pop) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                // completion and timeout both chain straight into the next entry
                if (done || timeout_hit) begin
                    if (can_pop) begin
                        pop        = 1'b1;
                        state_next = SETUP;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        xfer_cnt_next = xfer_cnt_reg;
        err_cnt_next  = err_cnt_reg;
        err_irq_next  = err_irq_reg;
        if (done && (xfer_cnt_reg != 16'hFFFF)) begin
            xfer_cnt_next = xfer_cnt_reg + 16'd1;
        end
        // a clear coinciding with a new error leaves exactly that one error recorded
        if (err_clr) begin
            err_irq_next = err_ev;
            err_cnt_next = err_ev ? 8'd1 : 8'd0;
        end else if (err_ev) begin
            err_irq_next = 1'b1;
            if (err_cnt_reg != 8'hFF) begin
                err_cnt_next = err_cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_reg    <= IDLE;
            armed_reg    <= 1'b0;
            tmo_cnt_reg  <= '0;
            paddr_reg    <= '0;
            pwdata_reg   <= '0;
            xfer_cnt_reg <= '0;
            err_cnt_reg  <= '0;
            err_irq_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            armed_reg    <= 1'b1;
            tmo_cnt_reg  <= tmo_cnt_next;
            xfer_cnt_reg <= xfer_cnt_next;
            err_cnt_reg  <= err_cnt_next;
            err_irq_reg  <= err_irq_next;
            if (pop) begin
                paddr_reg  <= fifo_addr;
                pwdata_reg <= fifo_rdata;
            end
        end
    end

    assign fifo_rinc = pop;
    assign paddr     = paddr_reg;
    assign pwdata    = pwdata_reg;
    assign pwrite    = 1'b1;
    assign psel      = (state_reg == SETUP) || (state_reg == ACCESS);
    assign penable   = (state_reg == ACCESS);
    assign busy      = (state_reg != IDLE);
    assign err_irq   = err_irq_reg;
    assign xfer_cnt  = xfer_cnt_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_apb_drain_ctrl.sv
// Bench for apb_drain_ctrl: emulates the FIFO with a queue, checks every cycle
// against a transfer-phase model, and pins scenario results with literal values.
module tb_apb_drain_ctrl;

    localparam int DSIZE  = 32;
    localparam int AWIDTH = 32;
    localparam int TMO    = 16;

    logic              rclk;
    logic              rrst_n;
    logic              enable;
    logic              fifo_rempty;
    logic [DSIZE-1:0]  fifo_rdata;
    logic [AWIDTH-1:0] fifo_addr;
    logic              fifo_rinc;
    logic [AWIDTH-1:0] paddr;
    logic [DSIZE-1:0]  pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic              pready;
    logic              pslverr;
    logic              busy;
    logic              err_irq;
    logic              err_clr;
    logic [15:0]       xfer_cnt;
    logic [7:0]        err_cnt;

    apb_drain_ctrl #(
        .DSIZE   (DSIZE),
        .AWIDTH  (AWIDTH),
        .TIMEOUT (TMO)
    ) dut (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .enable      (enable),
        .fifo_rempty (fifo_rempty),
        .fifo_rdata  (fifo_rdata),
        .fifo_addr   (fifo_addr),
        .fifo_rinc   (fifo_rinc),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pwrite      (pwrite),
        .psel        (psel),
        .penable     (penable),
        .pready      (pready),
        .pslverr     (pslverr),
        .busy        (busy),
        .err_irq     (err_irq),
        .err_clr     (err_clr),
        .xfer_cnt    (xfer_cnt),
        .err_cnt     (err_cnt)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int n_rinc, n_psel, n_pen, psel_run, psel_max;

    // model: m_ph counts cycles since the pop (0 idle, 1 setup, >=2 access)
    int          m_ph;
    bit          m_armed;
    logic [31:0] m_paddr, m_pwdata;
    int          m_xfer, m_err;
    bit          m_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        if (q.size() == 0) begin
            fifo_rempty = 1'b1;
            fifo_rdata  = '0;
            fifo_addr   = '0;
        end else begin
            fifo_rempty = 1'b0;
            fifo_rdata  = q[0].data;
            fifo_addr   = q[0].addr;
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        entry_t e;
        e.addr = a;
        e.data = d;
        q.push_back(e);
        drive_fifo();
    endtask

    task automatic clear_stats();
        n_rinc   = 0;
        n_psel   = 0;
        n_pen    = 0;
        psel_run = 0;
        psel_max = 0;
    endtask

    // one clock: sample outputs mid-cycle, then apply the FIFO pop after the edge
    task automatic tick();
        logic r;
        @(negedge rclk);
        #1;
        r = fifo_rinc;
        if (fifo_rinc) n_rinc++;
        if (psel) begin
            n_psel++;
            psel_run++;
            if (psel_run > psel_max) psel_max = psel_run;
        end else begin
            psel_run = 0;
        end
        if (penable) n_pen++;
        @(posedge rclk);
        #1;
        if (r && q.size() > 0) q.delete(0);
        drive_fifo();
        $display("cycle t=%0t rinc=%0b psel=%0b penable=%0b paddr=0x%0h xfer=%0d err=%0d irq=%0b",
                 $time, r, psel, penable, paddr, xfer_cnt, err_cnt, err_irq);
    endtask

    task automatic run_idle(input int max);
        for (int k = 0; k < max; k++) begin
            tick();
            if (!busy && (q.size() == 0 || !enable)) break;
        end
        chk("run_idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic wait_penable(input int max);
        for (int k = 0; k < max && !penable; k++) tick();
        chk("wait_penable", 32'(penable), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge rclk);
        #2 rrst_n = 1'b0;
        q.delete();
        drive_fifo();
        enable  = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge rclk);
        #1 rrst_n = 1'b1;
    endtask

    // per-cycle compare against the model
    always @(negedge rclk) begin : monitor
        bit e_rinc;
        bit ending;
        bit complete;
        bit err_ev;
        if (!rrst_n) begin
            m_ph    = 0;
            m_armed = 0;
            m_paddr = '0;
            m_pwdata = '0;
            m_xfer  = 0;
            m_err   = 0;
            m_irq   = 0;
        end
        ending   = (m_ph >= 2) && (pready || ((m_ph - 1) == TMO && !pready));
        complete = (m_ph >= 2) && pready;
        e_rinc   = rrst_n && m_armed && enable && !fifo_rempty && (m_ph == 0 || ending);

        chk("fifo_rinc", 32'(fifo_rinc), 32'(e_rinc));
        chk("psel",      32'(psel),      32'(m_ph >= 1));
        chk("penable",   32'(penable),   32'(m_ph >= 2));
        chk("busy",      32'(busy),      32'(m_ph != 0));
        chk("pwrite",    32'(pwrite),    32'd1);
        chk("paddr",     paddr,          m_paddr);
        chk("pwdata",    pwdata,         m_pwdata);
        chk("xfer_cnt",  32'(xfer_cnt),  32'(m_xfer));
        chk("err_cnt",   32'(err_cnt),   32'(m_err));
        chk("err_irq",   32'(err_irq),   32'(m_irq));

        if (rrst_n) begin
            err_ev = (complete && pslverr) || (ending && !pready);
            if (complete) m_xfer = (m_xfer < 65535) ? m_xfer + 1 : 65535;
            if (err_clr) begin
                m_irq = err_ev;
                m_err = err_ev ? 1 : 0;
            end else if (err_ev) begin
                m_irq = 1;
                m_err = (m_err < 255) ? m_err + 1 : 255;
            end
            if (e_rinc) begin
                m_paddr  = fifo_addr;
                m_pwdata = fifo_rdata;
                m_ph     = 1;
            end else if (ending) begin
                m_ph = 0;
            end else if (m_ph != 0) begin
                m_ph = m_ph + 1;
            end
            m_armed = 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rrst_n  = 1'b1;
        enable  = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
        err_clr = 1'b0;
        drive_fifo();
        clear_stats();
        #1 rrst_n = 1'b0;
        #1;
        chk("reset_psel",  32'(psel),     32'd0);
        chk("reset_paddr", paddr,         32'd0);
        chk("reset_xfer",  32'(xfer_cnt), 32'd0);
        repeat (2) @(posedge rclk);
        #1 rrst_n = 1'b1;

        // single write
        clear_stats();
        enable = 1'b1;
        pready = 1'b1;
        push(32'h10, 32'hA5A5_A5A5);
        run_idle(10);
        chk("single_rinc",  32'(n_rinc),   32'd1);
        chk("single_psel",  32'(n_psel),   32'd2);
        chk("single_xfer",  32'(xfer_cnt), 32'd1);
        chk("single_paddr", paddr,         32'h10);
        chk("single_pwdata", pwdata,       32'hA5A5_A5A5);

        // back-to-back burst
        do_reset();
        clear_stats();
        enable = 1'b1;
        pready = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 32'h1111_0000 + 32'(i));
        run_idle(20);
        chk("burst_rinc",     32'(n_rinc),   32'd4);
        chk("burst_psel_run", 32'(psel_max), 32'd8);
        chk("burst_xfer",     32'(xfer_cnt), 32'd4);

        // wait states then slave error; pslverr is high throughout the wait
        do_reset();
        clear_stats();
        enable  = 1'b1;
        pready  = 1'b0;
        pslverr = 1'b1;
        push(32'h20, 32'hDEAD_BEEF);
        wait_penable(10);
        repeat (3) tick();
        pready = 1'b1;
        tick();
        pready  = 1'b0;
        pslverr = 1'b0;
        chk("wait_pen_cycles", 32'(n_pen),    32'd4);
        chk("wait_err_cnt",    32'(err_cnt),  32'd1);
        chk("wait_err_irq",    32'(err_irq),  32'd1);
        chk("wait_xfer",       32'(xfer_cnt), 32'd1);

        // timeout, then a lone clear
        do_reset();
        clear_stats();
        enable = 1'b1;
        pready = 1'b0;
        push(32'h30, 32'h0BAD_F00D);
        run_idle(40);
        chk("tmo_psel_cycles", 32'(n_psel),   32'd17);
        chk("tmo_pen_cycles",  32'(n_pen),    32'd16);
        chk("tmo_err_cnt",     32'(err_cnt),  32'd1);
        chk("tmo_xfer",        32'(xfer_cnt), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_err_irq", 32'(err_irq), 32'd0);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);

        // enable dropped mid-access
        do_reset();
        clear_stats();
        enable = 1'b1;
        pready = 1'b0;
        push(32'h40, 32'h4);
        push(32'h44, 32'h5);
        push(32'h48, 32'h6);
        wait_penable(10);
        enable = 1'b0;
        tick();
        pready = 1'b1;
        run_idle(10);
        chk("endrop_rinc", 32'(n_rinc),   32'd1);
        chk("endrop_xfer", 32'(xfer_cnt), 32'd1);
        chk("endrop_left", 32'(q.size()), 32'd2);
        pslverr = 1'b1;
        repeat (3) tick();
        chk("pslverr_idle_ignored", 32'(err_cnt), 32'd0);
        pslverr = 1'b0;

        // reset during access, then first-pop delay after release
        pready = 1'b0;
        enable = 1'b1;
        clear_stats();
        wait_penable(10);
        #1 rrst_n = 1'b0;
        #1;
        chk("rst_psel",    32'(psel),     32'd0);
        chk("rst_penable", 32'(penable),  32'd0);
        chk("rst_xfer",    32'(xfer_cnt), 32'd0);
        chk("rst_err",     32'(err_cnt),  32'd0);
        repeat (2) @(posedge rclk);
        #1 rrst_n = 1'b1;
        clear_stats();
        pready = 1'b1;
        tick();
        chk("rst_no_early_pop", 32'(n_rinc), 32'd0);
        tick();
        chk("rst_second_edge_pop", 32'(n_rinc), 32'd1);
        run_idle(10);
        chk("rst_after_xfer", 32'(xfer_cnt), 32'd1);
        chk("rst_after_paddr", paddr, 32'h48);

        // error counter saturation and clear colliding with an error
        do_reset();
        clear_stats();
        enable  = 1'b1;
        pready  = 1'b1;
        pslverr = 1'b1;
        for (int i = 0; i < 256; i++) push(32'(i), 32'(i) ^ 32'hFFFF_0000);
        run_idle(1000);
        chk("sat_err_cnt", 32'(err_cnt),  32'hFF);
        chk("sat_xfer",    32'(xfer_cnt), 32'd256);
        chk("sat_err_irq", 32'(err_irq),  32'd1);
        push(32'h200, 32'h7);
        wait_penable(10);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_set_err_cnt", 32'(err_cnt),  32'd1);
        chk("clr_set_err_irq", 32'(err_irq),  32'd1);
        chk("clr_set_xfer",    32'(xfer_cnt), 32'd257);
        pslverr = 1'b0;
        pready  = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_drain_ctrl.md
APB_DRAIN_CTRL -- requirements
Module: apb_drain_ctrl

Interface
REQ-001 SHALL have parameter DSIZE, default 32: FIFO data and APB PWDATA width.
REQ-002 SHALL have parameter AWIDTH, default 32: FIFO address and APB PADDR width.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles waiting for pready; 0 disables the timeout.
REQ-004 SHALL have port rclk, input, 1: single clock, which is the FIFO read-side/APB clock; every register is clocked on its rising edge.
REQ-005 SHALL have port rrst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1: permits new FIFO pops.
REQ-007 SHALL have port fifo_rempty, input, 1: FIFO empty flag.
REQ-008 SHALL have port fifo_rdata, input, DSIZE: FIFO head data, valid while fifo_rempty=0.
REQ-009 SHALL have port fifo_addr, input, AWIDTH: FIFO head address, valid while fifo_rempty=0.
REQ-010 SHALL have port fifo_rinc, output, 1: FIFO pop strobe; one pulse pops one entry.
REQ-011 SHALL have APB master ports paddr (output, AWIDTH), pwdata (output, DSIZE), pwrite (output, 1), psel (output, 1) and penable (output, 1).
REQ-012 SHALL have APB response ports pready (input, 1) and pslverr (input, 1).
REQ-013 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-014 SHALL have port err_irq, output, 1: sticky error flag.
REQ-015 SHALL have port err_clr, input, 1: clears err_irq.
REQ-016 SHALL have port xfer_cnt, output, 16: count of completed transfers, saturating.
REQ-017 SHALL have port err_cnt, output, 8: count of error transfers, saturating.

Function
REQ-018 SHALL implement a state machine with states IDLE, SETUP and ACCESS.
REQ-019 IDLE: if enable=1 and fifo_rempty=0, SHALL assert fifo_rinc for exactly one cycle, latch fifo_addr into paddr and fifo_rdata into pwdata on the same edge, and go to SETUP.
REQ-020 SETUP: SHALL drive psel=1, penable=0 for exactly one cycle, then go to ACCESS.
REQ-021 ACCESS: SHALL drive psel=1, penable=1 and hold paddr/pwdata stable until pready=1 or timeout.
REQ-022 pwrite SHALL be constant 1; every FIFO entry is one APB write.
REQ-023 On completion (ACCESS with pready=1): if enable=1 and fifo_rempty=0, SHALL pop and latch the next entry in that same cycle and go to SETUP (back-to-back); otherwise SHALL go to IDLE.
REQ-024 In any one ACCESS wait, the timeout counter SHALL increment per cycle with pready=0; reaching TIMEOUT SHALL end the transfer as an error, drop psel/penable the next cycle, and apply REQ-023 sequencing.
REQ-025 On completion, xfer_cnt SHALL increment by 1, saturating at 16'hFFFF.
REQ-026 On completion with pslverr=1, or on timeout, err_cnt SHALL increment by 1 (saturating at 8'hFF) and err_irq SHALL set.
REQ-027 Timeout SHALL NOT increment xfer_cnt.
REQ-028 err_clr=1 SHALL clear err_irq and err_cnt; if an error event occurs in the same cycle, err_irq=1 and err_cnt=1 SHALL result (set wins).
REQ-029 Deasserting enable SHALL NOT abort an in-flight transfer; it only blocks further pops.
REQ-030 fifo_rinc SHALL never assert while fifo_rempty=1, and SHALL assert at most once per transfer.
REQ-031 pslverr SHALL be ignored outside ACCESS with pready=1.
REQ-032 Minimum spacing SHALL be 2 cycles per transfer back-to-back and 3 cycles from IDLE.

Reset
REQ-033 rrst_n=0 SHALL immediately force state=IDLE; fifo_rinc, psel, penable, busy and err_irq to 0; paddr, pwdata, xfer_cnt, err_cnt and the timeout counter to 0; pwrite to 1.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer with no counter update; after release, the first pop SHALL occur no earlier than the second rising edge.

Verification
REQ-035 Single write: FIFO holds {addr=0x10, data=0xA5A5A5A5}, enable=1, pready=1 -> one fifo_rinc pulse, SETUP then ACCESS with paddr=0x10, pwdata=0xA5A5A5A5; xfer_cnt=1; back to IDLE.
REQ-036 Burst: 4 entries, pready=1 always -> 4 pops, 8 consecutive psel cycles with no IDLE gap; xfer_cnt=4.
REQ-037 Wait states and error: pready low for 3 ACCESS cycles, then pready=1 with pslverr=1 -> paddr held for 4 ACCESS cycles; err_cnt=1, err_irq=1, xfer_cnt=1.
REQ-038 Timeout: TIMEOUT=16, pready held 0 -> psel drops after 16 ACCESS cycles; err_cnt=1, xfer_cnt unchanged.
REQ-039 Enable/reset: enable dropped during ACCESS with 2 entries pending -> current transfer completes with no further pop; rrst_n pulsed low during ACCESS -> psel=0 immediately and all counters read 0.
REQ-040 Saturation and clear: 256 error transfers -> err_cnt=0xFF; err_clr pulsed together with an error event -> err_irq=1, err_cnt=1.
